// File: rtl/bsg_gateway_pkg.sv
// rtl/bsg_gateway_pkg.sv - shared state encoding and sizing helpers for the gateway power sequencer
package bsg_gateway_pkg;

  localparam int state_width_lp = 3;

  typedef enum logic [state_width_lp-1:0] {
    S_OFF      = 3'd0,
    S_CORE_ON  = 3'd1,
    S_IO_ON    = 3'd2,
    S_RST_HOLD = 3'd3,
    S_RUN      = 3'd4,
    S_IO_OFF   = 3'd5,
    S_CORE_OFF = 3'd6,
    S_FAULT    = 3'd7
  } state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/bsg_gateway_power_seq_timer.sv
// rtl/bsg_gateway_power_seq_timer.sv - loadable down-counter that parks at zero and flags it
module bsg_gateway_power_seq_timer #(
  parameter int width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               load_i,
  input  logic [width_p-1:0] load_val_i,
  output logic               zero_o
);

  logic [width_p-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - width_p'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/bsg_gateway_power_seq.sv
// rtl/bsg_gateway_power_seq.sv - ordered core/IO/clock/reset bring-up and teardown for the ASIC under test
module bsg_gateway_power_seq
  import bsg_gateway_pkg::*;
#(
  parameter int core_delay_p   = 1024,
  parameter int io_delay_p     = 1024,
  parameter int reset_cycles_p = 256
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      en_i,
  input  logic                      fault_i,
  input  logic                      fault_clear_i,
  output logic                      core_en_o,
  output logic                      io_en_o,
  output logic                      asic_clk_en_o,
  output logic                      asic_reset_o,
  output logic                      ready_o,
  output logic                      fault_o,
  output logic [state_width_lp-1:0] state_o
);

  localparam int cnt_w_lp = $clog2(max3(core_delay_p, io_delay_p, reset_cycles_p)) + 1;

  localparam logic [cnt_w_lp-1:0] core_ld_lp  = cnt_w_lp'(core_delay_p - 1);
  localparam logic [cnt_w_lp-1:0] io_ld_lp    = cnt_w_lp'(io_delay_p - 1);
  localparam logic [cnt_w_lp-1:0] reset_ld_lp = cnt_w_lp'(reset_cycles_p - 1);

  state_e              state_q, state_d;
  logic                tmr_load;
  logic [cnt_w_lp-1:0] tmr_load_val;
  logic                tmr_zero;

  bsg_gateway_power_seq_timer #(
    .width_p(cnt_w_lp)
  ) timer (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .load_i    (tmr_load),
    .load_val_i(tmr_load_val),
    .zero_o    (tmr_zero)
  );

  // Fault beats everything; inside each state a dropped en_i beats timer expiry.
  always_comb begin
    state_d = state_q;
    if (fault_i && (state_q != S_FAULT)) begin
      state_d = S_FAULT;
    end else begin
      unique case (state_q)
        S_OFF:      if (en_i) state_d = S_CORE_ON;
        S_CORE_ON:  if (!en_i) state_d = S_CORE_OFF;
                    else if (tmr_zero) state_d = S_IO_ON;
        S_IO_ON:    if (!en_i) state_d = S_IO_OFF;
                    else if (tmr_zero) state_d = S_RST_HOLD;
        S_RST_HOLD: if (!en_i) state_d = S_IO_OFF;
                    else if (tmr_zero) state_d = S_RUN;
        S_RUN:      if (!en_i) state_d = S_IO_OFF;
        S_IO_OFF:   if (tmr_zero) state_d = S_CORE_OFF;
        S_CORE_OFF: if (tmr_zero) state_d = S_OFF;
        S_FAULT:    if (fault_clear_i && !fault_i && !en_i) state_d = S_OFF;
        default:    state_d = S_OFF;
      endcase
    end
  end

  // Timer reloads on every state change so each timed state runs its full delay.
  always_comb begin
    tmr_load     = (state_d != state_q);
    tmr_load_val = '0;
    unique case (state_d)
      S_CORE_ON, S_CORE_OFF: tmr_load_val = core_ld_lp;
      S_IO_ON, S_IO_OFF:     tmr_load_val = io_ld_lp;
      S_RST_HOLD:            tmr_load_val = reset_ld_lp;
      default:               tmr_load_val = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= S_OFF;
    end else begin
      state_q <= state_d;
    end
  end

  logic core_en_d, io_en_d, clk_en_d, asic_reset_d, ready_d, fault_d;
  logic core_en_q, io_en_q, clk_en_q, asic_reset_q, ready_q, fault_q;
  state_e state_o_q;

  always_comb begin
    core_en_d    = 1'b0;
    io_en_d      = 1'b0;
    clk_en_d     = 1'b0;
    asic_reset_d = 1'b1;
    ready_d      = 1'b0;
    fault_d      = 1'b0;
    unique case (state_q)
      S_CORE_ON:  core_en_d = 1'b1;
      S_IO_ON: begin
        core_en_d = 1'b1;
        io_en_d   = 1'b1;
      end
      S_RST_HOLD: begin
        core_en_d = 1'b1;
        io_en_d   = 1'b1;
        clk_en_d  = 1'b1;
      end
      S_RUN: begin
        core_en_d    = 1'b1;
        io_en_d      = 1'b1;
        clk_en_d     = 1'b1;
        asic_reset_d = 1'b0;
        ready_d      = 1'b1;
      end
      S_IO_OFF:   core_en_d = 1'b1;
      S_FAULT:    fault_d = 1'b1;
      default:    ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      core_en_q    <= 1'b0;
      io_en_q      <= 1'b0;
      clk_en_q     <= 1'b0;
      asic_reset_q <= 1'b1;
      ready_q      <= 1'b0;
      fault_q      <= 1'b0;
      state_o_q    <= S_OFF;
    end else begin
      core_en_q    <= core_en_d;
      io_en_q      <= io_en_d;
      clk_en_q     <= clk_en_d;
      asic_reset_q <= asic_reset_d;
      ready_q      <= ready_d;
      fault_q      <= fault_d;
      state_o_q    <= state_q;
    end
  end

  assign core_en_o     = core_en_q;
  assign io_en_o       = io_en_q;
  assign asic_clk_en_o = clk_en_q;
  assign asic_reset_o  = asic_reset_q;
  assign ready_o       = ready_q;
  assign fault_o       = fault_q;
  assign state_o       = state_o_q;

endmodule

// File: tb/tb_bsg_gateway_power_seq.sv
// tb/tb_bsg_gateway_power_seq.sv - directed checks of sequencing, abort, fault and reset behaviour
module tb_bsg_gateway_power_seq;

  logic       clk;
  logic       resetn;
  logic       en;
  logic       fault;
  logic       clr;
  logic       core_en, io_en, clk_en, asic_rst, ready, fault_o;
  logic [2:0] state_o;

  int nvec = 0;
  int nerr = 0;

  bsg_gateway_power_seq #(
    .core_delay_p  (4),
    .io_delay_p    (3),
    .reset_cycles_p(5)
  ) dut (
    .clk_i        (clk),
    .reset_n_i    (resetn),
    .en_i         (en),
    .fault_i      (fault),
    .fault_clear_i(clr),
    .core_en_o    (core_en),
    .io_en_o      (io_en),
    .asic_clk_en_o(clk_en),
    .asic_reset_o (asic_rst),
    .ready_o      (ready),
    .fault_o      (fault_o),
    .state_o      (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [6:0] got;
    repeat (2) step();
    got = {core_en, io_en, clk_en, asic_rst, ready, fault_o, 1'b0};
    nvec++;
    if (got !== 7'b0001000) begin
      nerr++;
      $display("FAIL reset_outputs: got %b want %b", got, 7'b0001000);
    end
    nvec++;
    if (state_o !== 3'd0) begin
      nerr++;
      $display("FAIL reset_state: got %0d want 0", state_o);
    end
    resetn = 1'b1;
    step();
  endtask

  // Requires state OFF; first edge after the call samples en_i high (edge 0).
  task automatic test_power_up();
    logic [4:0] got, exp;
    en = 1'b1;
    for (int k = 0; k <= 14; k++) begin
      step();
      got = {core_en, io_en, clk_en, asic_rst, ready};
      exp = {k >= 1, k >= 5, k >= 8, k < 13, k >= 13};
      nvec++;
      if (got !== exp) begin
        nerr++;
        $display("FAIL power_up k=%0d: got %b want %b", k, got, exp);
      end
      if (k == 13) begin
        nvec++;
        if (state_o !== 3'd4) begin
          nerr++;
          $display("FAIL power_up_state: got %0d want 4", state_o);
        end
      end
    end
  endtask

  task automatic test_power_down();
    logic [4:0] got, exp;
    logic [2:0] exp_st;
    en = 1'b0;
    for (int k = 0; k <= 9; k++) begin
      step();
      got = {core_en, io_en, clk_en, asic_rst, ready};
      if (k == 0) exp = 5'b11101;
      else if (k < 4) exp = 5'b10010;
      else exp = 5'b00010;
      exp_st = (k < 1) ? 3'd4 : (k < 4) ? 3'd5 : (k < 8) ? 3'd6 : 3'd0;
      nvec++;
      if (got !== exp || state_o !== exp_st) begin
        nerr++;
        $display("FAIL power_down k=%0d: got %b/%0d want %b/%0d", k, got, state_o, exp, exp_st);
      end
    end
  endtask

  task automatic test_abort();
    logic [2:0] exp_st;
    logic       exp_core, exp_io;
    en = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      step();
      if (k < 1) exp_st = 3'd0;
      else if (k < 5) exp_st = 3'd1;
      else if (k < 7) exp_st = 3'd2;
      else if (k < 10) exp_st = 3'd5;
      else if (k < 14) exp_st = 3'd6;
      else if (k < 15) exp_st = 3'd0;
      else exp_st = 3'd1;
      exp_core = (k >= 1 && k <= 9) || (k >= 15);
      exp_io   = (k == 5) || (k == 6);
      nvec++;
      if (state_o !== exp_st || core_en !== exp_core || io_en !== exp_io) begin
        nerr++;
        $display("FAIL abort k=%0d: got st=%0d core=%b io=%b want st=%0d core=%b io=%b",
                 k, state_o, core_en, io_en, exp_st, exp_core, exp_io);
      end
      if (k == 5) en = 1'b0;
      if (k == 6) en = 1'b1;
    end
    en = 1'b0;
    repeat (10) step();
    nvec++;
    if (state_o !== 3'd0) begin
      nerr++;
      $display("FAIL abort_settle: got %0d want 0", state_o);
    end
  endtask

  task automatic bring_up();
    en = 1'b1;
    repeat (14) step();
    nvec++;
    if (ready !== 1'b1) begin
      nerr++;
      $display("FAIL bring_up_ready: got %b want 1", ready);
    end
  endtask

  task automatic test_fault();
    logic [5:0] got;
    bring_up();
    fault = 1'b1;
    step();
    fault = 1'b0;
    nvec++;
    if (ready !== 1'b1) begin
      nerr++;
      $display("FAIL fault_lag: ready got %b want 1", ready);
    end
    step();
    got = {core_en, io_en, clk_en, asic_rst, ready, fault_o};
    nvec++;
    if (got !== 6'b000101 || state_o !== 3'd7) begin
      nerr++;
      $display("FAIL fault_entry: got %b/%0d want 000101/7", got, state_o);
    end
    clr = 1'b1;
    repeat (3) step();
    nvec++;
    if (fault_o !== 1'b1 || state_o !== 3'd7) begin
      nerr++;
      $display("FAIL fault_hold_en: got fault=%b st=%0d want 1/7", fault_o, state_o);
    end
    en = 1'b0;
    repeat (2) step();
    clr = 1'b0;
    nvec++;
    if (fault_o !== 1'b0 || state_o !== 3'd0 || asic_rst !== 1'b1) begin
      nerr++;
      $display("FAIL fault_clear: got fault=%b st=%0d rst=%b want 0/0/1", fault_o, state_o, asic_rst);
    end
  endtask

  task automatic test_reset_mid();
    logic [5:0] got;
    en = 1'b1;
    repeat (10) step();
    nvec++;
    if (clk_en !== 1'b1 || asic_rst !== 1'b1) begin
      nerr++;
      $display("FAIL rst_hold: got clk_en=%b rst=%b want 1/1", clk_en, asic_rst);
    end
    resetn = 1'b0;
    step();
    got = {core_en, io_en, clk_en, asic_rst, ready, fault_o};
    nvec++;
    if (got !== 6'b000100 || state_o !== 3'd0) begin
      nerr++;
      $display("FAIL reset_mid: got %b/%0d want 000100/0", got, state_o);
    end
    resetn = 1'b1;
    test_power_up();
    en = 1'b0;
    repeat (12) step();
    nvec++;
    if (state_o !== 3'd0) begin
      nerr++;
      $display("FAIL reset_mid_settle: got %0d want 0", state_o);
    end
  endtask

  task automatic test_simultaneous();
    bring_up();
    en    = 1'b0;
    fault = 1'b1;
    step();
    fault = 1'b0;
    step();
    nvec++;
    if (state_o !== 3'd7 || fault_o !== 1'b1 || core_en !== 1'b0) begin
      nerr++;
      $display("FAIL fault_vs_en: got st=%0d fault=%b core=%b want 7/1/0", state_o, fault_o, core_en);
    end
    clr = 1'b1;
    repeat (2) step();
    clr = 1'b0;
    nvec++;
    if (state_o !== 3'd0) begin
      nerr++;
      $display("FAIL simul_clear: got %0d want 0", state_o);
    end
    en = 1'b1;
    for (int k = 0; k <= 9; k++) begin
      step();
      if (k == 4) begin
        nvec++;
        if (state_o !== 3'd1 || core_en !== 1'b1) begin
          nerr++;
          $display("FAIL expiry_pre: got st=%0d core=%b want 1/1", state_o, core_en);
        end
      end
      if (k == 5 || k == 8) begin
        nvec++;
        if (state_o !== 3'd6 || core_en !== 1'b0 || io_en !== 1'b0) begin
          nerr++;
          $display("FAIL expiry_vs_en k=%0d: got st=%0d core=%b io=%b want 6/0/0", k, state_o, core_en, io_en);
        end
      end
      if (k == 9) begin
        nvec++;
        if (state_o !== 3'd0) begin
          nerr++;
          $display("FAIL expiry_off: got %0d want 0", state_o);
        end
      end
      if (k == 3) en = 1'b0;
    end
  endtask

  initial begin
    resetn = 1'b0;
    en     = 1'b0;
    fault  = 1'b0;
    clr    = 1'b0;
    test_reset();
    test_power_up();
    test_power_down();
    test_abort();
    test_fault();
    test_reset_mid();
    test_simultaneous();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/bsg_gateway_power_seq.md
# bsg_gateway_power_seq

Gateway-FPGA power and reset sequencer for the ASIC under test. It sits directly upstream of the gateway socket's rail-enable pins (ASIC_CORE_EN, ASIC_IO_EN) and the gateway chip's ASIC clock-output enable and ASIC reset pin. It brings rails up in order: core, then IO, then clocks with reset held. It releases reset after a fixed hold, tears down in reverse order on request, and collapses to a safe state on fault.

## Interface
Parameters:
- core_delay_p, 1024: cycles between core_en_o and io_en_o on power-up, and between io_en_o fall and core_en_o fall on power-down. Must be ≥1.
- io_delay_p, 1024: cycles from io_en_o rise to asic_clk_en_o rise; also the IO-off settle time on power-down. Must be ≥1.
- reset_cycles_p, 256: cycles the ASIC clock runs with asic_reset_o held before release. Must be ≥1.

Ports:
- clk_i, input, 1: gateway core clock.
- reset_n_i, input, 1: synchronous, active-low reset.
- en_i, input, 1: level power request; 1 = power up / stay up, 0 = power down.
- fault_i, input, 1: rail/current-monitor fault; level-sensitive.
- fault_clear_i, input, 1: leaves FAULT.
- core_en_o, output, 1: core rail enable.
- io_en_o, output, 1: IO rail enable.
- asic_clk_en_o, output, 1: enables the ASIC clock outputs.
- asic_reset_o, output, 1: ASIC reset, active-high.
- ready_o, output, 1: ASIC powered, clocked and out of reset.
- fault_o, output, 1: high while in FAULT.
- state_o, output, 3: current state encoding, for debug/LEDs.

## Operation
- Reset values: core_en_o=0, io_en_o=0, asic_clk_en_o=0, asic_reset_o=1, ready_o=0, fault_o=0, state=OFF.
- Outputs are registered and decoded purely from state.
- Down-counter: loaded with (delay−1) on each state entry; the state advances on the cycle the counter reads 0. Each timed state therefore lasts exactly its delay in cycles.
- Counter width: clog2 of max(core_delay_p, io_delay_p, reset_cycles_p) + 1.

States, with their outputs and transitions:
- OFF (all enables 0, reset 1): en_i & ~fault_i → CORE_ON.
- CORE_ON (core_en): after core_delay_p → IO_ON. If en_i=0 → CORE_OFF.
- IO_ON (core_en, io_en): after io_delay_p → RST_HOLD. If en_i=0 → IO_OFF.
- RST_HOLD (core_en, io_en, clk_en, reset 1): after reset_cycles_p → RUN. If en_i=0 → IO_OFF.
- RUN (core_en, io_en, clk_en, reset 0, ready 1): en_i=0 → IO_OFF.
- IO_OFF (core_en only, reset 1): lasts io_delay_p → CORE_OFF.
- CORE_OFF (all 0, reset 1): lasts core_delay_p → OFF.
- FAULT (all 0, reset 1, fault_o 1): fault_clear_i & ~fault_i & ~en_i → OFF. Otherwise FAULT is held.

Boundary conditions:
- fault_i=1 in any state other than FAULT → FAULT on the next edge. Fault has priority over en_i and timer expiry.
- en_i dropping in CORE_ON/IO_ON/RST_HOLD aborts the current timer immediately; the new state's timer loads fresh.
- en_i re-asserting during IO_OFF/CORE_OFF is ignored; the power-down sequence completes to OFF. If en_i is still high in OFF, power-up restarts.
- Timer expiry and en_i=0 in the same cycle: en_i=0 wins.
- reset_n_i low at any point: next edge forces reset values. Rails drop immediately, with no ordered teardown.

## Timing
- Power-up, en_i sampled high at edge 0 in OFF:
  - core_en_o high from cycle 1;
  - io_en_o from 1+core_delay_p;
  - asic_clk_en_o from 1+core_delay_p+io_delay_p;
  - asic_reset_o low and ready_o high from 1+core_delay_p+io_delay_p+reset_cycles_p.
- Power-down, en_i sampled low at edge T in RUN:
  - ready_o/asic_clk_en_o/io_en_o low and asic_reset_o high at T+1;
  - core_en_o low at T+1+io_delay_p;
  - OFF reached at T+1+io_delay_p+core_delay_p.
- Fault response: one cycle from fault_i to all enables low.

## Structure
- Shared package bsg_gateway_pkg:
  - 3-bit state enum, in order OFF=0, CORE_ON, IO_ON, RST_HOLD, RUN, IO_OFF, CORE_OFF, FAULT=7;
  - its width constant.
- One sub-module: bsg_gateway_power_seq_timer. Loadable down-counter with a zero flag, parameterized by width.
- FSM and output decode live in the top module.

## Test plan
All scenarios use core_delay_p=4, io_delay_p=3, reset_cycles_p=5.
- Power-up: en_i high at edge 0 → core_en at cycle 1, io_en at 5, clk_en at 8, reset low/ready at 13.
- Power-down from RUN: en_i low at edge T → io_en/clk_en low and reset high at T+1; core_en low at T+4; state_o=OFF at T+8.
- Abort and re-request: en_i low at cycle 6 (in IO_ON) → IO_OFF then CORE_OFF. en_i high again at 7 → ignored until OFF at 14; core_en rises at 15.
- Fault: fault_i pulse in RUN → all enables 0 and fault_o=1 next cycle. Clear ignored while en_i=1; with en_i=0 and fault_clear_i=1 → OFF.
- Reset mid-sequence: reset_n_i low in RST_HOLD → next edge shows reset values. Sequence restarts cleanly after release.
- Simultaneous events: fault_i and en_i fall together in RUN → FAULT, not IO_OFF. Timer expiry coincident with en_i=0 in CORE_ON → CORE_OFF.
